pc_stack_unit: RTL
==================

# pc_stack_unit

Parametrised program-counter unit for the next-generation hc816 core. It replaces the split 8-bit high/low counter pair with a single ADDR_WIDTH-bit counter. The unit supports increment, conditional absolute jump, conditional signed relative branch, and a hardware call/return stack with sticky fault flags. It drives the program ROM address and takes jump targets from the index-register datapath.

## Interface
- ADDR_WIDTH, default 16: PC and stack entry width, legal range 8..32.
- STACK_DEPTH, default 4: number of return-address entries, legal range 1..16.
- RESET_VECTOR, default 0: PC value loaded on reset, truncated to ADDR_WIDTH.

Ports:
- clk  in  1  the only clock; all state updates on the rising edge.
- nReset  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- nEnable  in  1  active-low stall; when 1, all state holds.
- op  in  3  operation code:
  - 000 hold
  - 001 inc
  - 010 jump
  - 011 branch
  - 100 call
  - 101 ret
  - 110 and 111 are treated as hold.
- cond  in  1  qualifies jump and branch; ignored by the other ops.
- target  in  ADDR_WIDTH  absolute destination for jump and call.
- offset  in  8  two's-complement displacement for branch.
- pc  out  ADDR_WIDTH  current program counter, registered.
- stack_level  out  $clog2(STACK_DEPTH+1)  number of valid stack entries.
- overflow  out  1  sticky; set by a call on a full stack.
- underflow  out  1  sticky; set by a ret on an empty stack.

## Operation
- Priority per edge: nReset=0 first, then nEnable=1 (hold), then op.
- Reset values:
  - pc = RESET_VECTOR
  - stack_level = 0
  - overflow = 0, underflow = 0
  - stack contents are don't-care.
- hold: no state change.
- inc: pc <= pc + 1.
- jump:
  - cond=1: pc <= target.
  - cond=0: pc <= pc + 1.
- branch:
  - cond=1: pc <= pc + sign_extend(offset); the displacement is relative to the current pc, not pc+1.
  - cond=0: pc <= pc + 1.
- call:
  - Not full: push pc + 1, then pc <= target, stack_level += 1.
  - Full (level == STACK_DEPTH): no push, overflow <= 1, pc <= pc + 1. The call is suppressed.
- ret:
  - Not empty: pc <= top entry, stack_level -= 1.
  - Empty: overflow unchanged, underflow <= 1, pc <= pc + 1.
- All PC arithmetic is modulo 2^ADDR_WIDTH:
  - all-ones + 1 = 0
  - 0 + (-1) = all-ones
  - the pushed return address wraps the same way.
- The stack is LIFO, indexed by stack_level. The top entry is index stack_level-1.
- overflow and underflow are sticky. Only reset clears them. They do not block later operations.

## Timing
- Every op takes effect at the rising edge where it is sampled. pc shows the new value one cycle after op is presented, and there is no further latency.
- stack_level and the flags update on the same edge as pc.
- Inputs are sampled only at the edge; there are no combinational paths from inputs to outputs.
- Back-to-back call/ret on consecutive cycles is legal. ret may pop an entry pushed on the immediately preceding edge.
- Reset mid-sequence: if nReset is low on an edge, the outputs return to their reset values on that edge regardless of op or nEnable.
- Stall: with nEnable=1 the outputs are frozen; resuming continues from the frozen state.

## Configuration
- Macro PC_CALL_STACK_EN.
- Defined: the call/return stack, stack_level, overflow and underflow behave as described above.
- Undefined:
  - No stack storage is built.
  - call behaves as an unconditional jump to target.
  - ret behaves as inc.
  - stack_level, overflow and underflow are tied to 0.

## Test plan
- Reset and inc:
  - Stimulus: RESET_VECTOR=16'h0100, release reset, inc for 3 cycles.
  - Required: pc = 0100, 0101, 0102, 0103; flags 0.
- Conditional jump and branch:
  - Stimulus at pc=0x0010: jump target=0x1234 cond=0.
  - Required: pc=0x0011.
  - Then jump target=0x1234 cond=1 → 0x1234.
  - Then branch offset=8'hF0 cond=1 → 0x1224.
- Wrap-around:
  - Stimulus: pc=0xFFFF, inc.
  - Required: pc=0x0000.
  - Then branch offset=8'hFF cond=1 → 0xFFFF.
- Nested calls to overflow, STACK_DEPTH=4:
  - Stimulus: 5 calls from pc 0x0000 targets 0x0100, 0x0200, 0x0300, 0x0400, 0x0500.
  - Required: stack_level reaches 4; the fifth call leaves pc=0x0401, sets overflow=1, stack_level stays 4.
  - Then 4 rets return pc = 0x0301, 0x0201, 0x0101, 0x0001.
- Underflow and stall:
  - Stimulus: ret at level 0 with pc=0x0001.
  - Required: pc=0x0002, underflow=1.
  - Then nEnable=1 with op=inc for 3 cycles: pc holds 0x0002.
- Reset mid-operation:
  - Stimulus: stack_level=2 with overflow=1, assert nReset=0 for one edge together with op=call.
  - Required: pc=RESET_VECTOR, stack_level=0, both flags 0.
  - Repeat the suite with PC_CALL_STACK_EN undefined: call → pc=target, ret → pc+1, stack_level, overflow and underflow stay 0.

Source files
------------

// File: rtl/pc_stack_unit.sv
// pc_stack_unit: ADDR_WIDTH-bit program counter for the hc816 core.
// Supports increment, conditional jump, signed relative branch and an
// optional hardware call/return stack with sticky overflow/underflow flags.
// Build option: define PC_CALL_STACK_EN to build the call/return stack.
// Without it, call is a plain jump, ret is an increment and the stack
// status outputs are tied to zero.
module pc_stack_unit #(
  parameter int          ADDR_WIDTH   = 16,
  parameter int          STACK_DEPTH  = 4,
  parameter logic [31:0] RESET_VECTOR = 32'h0
) (
  input  logic                             clk,
  input  logic                             nReset,
  input  logic                             nEnable,
  input  logic [2:0]                       op,
  input  logic                             cond,
  input  logic [ADDR_WIDTH-1:0]            target,
  input  logic [7:0]                       offset,
  output logic [ADDR_WIDTH-1:0]            pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_level,
  output logic                             overflow,
  output logic                             underflow
);

  localparam int LVL_W = $clog2(STACK_DEPTH + 1);
  localparam logic [ADDR_WIDTH-1:0] RESET_PC = RESET_VECTOR[ADDR_WIDTH-1:0];

  localparam logic [2:0] OP_HOLD   = 3'b000;
  localparam logic [2:0] OP_INC    = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_BRANCH = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [ADDR_WIDTH-1:0] pc_reg;
  logic [ADDR_WIDTH-1:0] pc_next;
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [ADDR_WIDTH-1:0] pc_rel;
  logic [ADDR_WIDTH-1:0] offset_ext;

  // Both candidate addresses wrap naturally at ADDR_WIDTH bits; the branch
  // displacement is applied to the current pc, not pc+1.
  assign pc_inc     = pc_reg + ADDR_WIDTH'(1);
  assign offset_ext = ADDR_WIDTH'($signed(offset));
  assign pc_rel     = pc_reg + offset_ext;

`ifdef PC_CALL_STACK_EN
  logic [LVL_W-1:0]      level_reg;
  logic [LVL_W-1:0]      level_next;
  logic [LVL_W-1:0]      top_idx;
  logic                  overflow_reg;
  logic                  overflow_next;
  logic                  underflow_reg;
  logic                  underflow_next;
  logic                  push_en;
  logic                  stack_full;
  logic                  stack_empty;
  logic [ADDR_WIDTH-1:0] top_entry;
  logic [STACK_DEPTH-1:0] write_sel;
  logic [STACK_DEPTH-1:0] read_sel;
  logic [ADDR_WIDTH-1:0] stack_mem [STACK_DEPTH];

  assign stack_full  = (level_reg == LVL_W'(STACK_DEPTH));
  assign stack_empty = (level_reg == '0);
  assign top_idx     = level_reg - LVL_W'(1);

  // One-hot slot selects: a push lands at index level, a pop reads level-1.
  genvar gi;
  generate
    for (gi = 0; gi < STACK_DEPTH; gi++) begin : g_slot
      assign write_sel[gi] = (level_reg == LVL_W'(gi));
      assign read_sel[gi]  = (top_idx == LVL_W'(gi));
    end
  endgenerate

  // Top-of-stack mux; ret must see the entry on the same edge it pops it.
  always_comb begin
    top_entry = '0;
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (read_sel[i]) begin
        top_entry = stack_mem[i];
      end
    end
  end

  // Return-address storage; contents need no reset since level gates reads.
  always_ff @(posedge clk) begin
    for (int i = 0; i < STACK_DEPTH; i++) begin
      if (nReset && push_en && write_sel[i]) begin
        stack_mem[i] <= pc_inc;
      end
    end
  end

  // Stack pointer and sticky fault flags.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      level_reg     <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      level_reg     <= level_next;
      overflow_reg  <= overflow_next;
      underflow_reg <= underflow_next;
    end
  end

  assign stack_level = level_reg;
  assign overflow    = overflow_reg;
  assign underflow   = underflow_reg;
`else
  assign stack_level = '0;
  assign overflow    = 1'b0;
  assign underflow   = 1'b0;
`endif

  // Next-state decode for pc and (when built) the stack; stall holds all.
  always_comb begin
    pc_next        = pc_reg;
`ifdef PC_CALL_STACK_EN
    level_next     = level_reg;
    overflow_next  = overflow_reg;
    underflow_next = underflow_reg;
    push_en        = 1'b0;
`endif
    if (!nEnable) begin
      case (op)
        OP_HOLD:   pc_next = pc_reg;
        OP_INC:    pc_next = pc_inc;
        OP_JUMP:   pc_next = cond ? target : pc_inc;
        OP_BRANCH: pc_next = cond ? pc_rel : pc_inc;
`ifdef PC_CALL_STACK_EN
        OP_CALL: begin
          if (stack_full) begin
            // Suppressed call: fall through to the next instruction.
            overflow_next = 1'b1;
            pc_next       = pc_inc;
          end else begin
            push_en    = 1'b1;
            pc_next    = target;
            level_next = level_reg + LVL_W'(1);
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            underflow_next = 1'b1;
            pc_next        = pc_inc;
          end else begin
            pc_next    = top_entry;
            level_next = level_reg - LVL_W'(1);
          end
        end
`else
        OP_CALL:   pc_next = target;
        OP_RET:    pc_next = pc_inc;
`endif
        default:   pc_next = pc_reg;
      endcase
    end
  end

  // Program counter register.
  always_ff @(posedge clk) begin
    if (!nReset) begin
      pc_reg <= RESET_PC;
    end else begin
      pc_reg <= pc_next;
    end
  end

  assign pc = pc_reg;

endmodule
